// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and widths for the wall-clock time-setting controller.
package clock_ctrl_pkg;

    // Controller state, also driven out as the mode field.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_e;

    // Inactivity timeout counter width (counts tick_1hz pulses).
    localparam int unsigned TO_W = 6;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Front-panel / counter-side signal bundle of clock_set_ctrl.
// master: button/prescaler side (drives inputs); slave: the controller.
interface clock_set_ctrl_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       run_en;
    logic       inc_h;
    logic       inc_m;
    logic       inc_s;
    logic       clr_s;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output tick_1hz, btn_mode, btn_inc,
        input  run_en, inc_h, inc_m, inc_s, clr_s, mode, blink
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc,
        output run_en, inc_h, inc_m, inc_s, clr_s, mode, blink
    );
endinterface

// File: rtl/clock_set_ctrl_inc_pulse_gen.sv
// Increment event generator: rising-edge detect on btn_inc.
// Optional macro AUTO_REPEAT_EN adds a hold counter producing repeat events.
module inc_pulse_gen
`ifdef AUTO_REPEAT_EN
#(
    parameter int unsigned REPEAT_START  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic en,
`ifdef AUTO_REPEAT_EN
    input  logic clr,
`endif
    input  logic btn_inc,
    output logic inc_evt_c
);

    logic hist_q;
    logic edge_c;

    // History register; deliberately not reset on mode changes.
    always_ff @(posedge clk) begin
        if (rst) hist_q <= 1'b0;
        else     hist_q <= btn_inc;
    end

    assign edge_c = btn_inc & ~hist_q;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    logic              armed_q;
    logic              phase_q;
    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_inc_c;
    logic              rep_c;

    // Repeat fires when the held-cycle count hits the start delay, then each period.
    always_comb begin
        cnt_inc_c = cnt_q + HOLD_W'(1);
        rep_c     = 1'b0;
        if (armed_q && btn_inc && hist_q) begin
            if (phase_q) rep_c = (cnt_inc_c == HOLD_W'(REPEAT_PERIOD));
            else         rep_c = (cnt_inc_c == HOLD_W'(REPEAT_START));
        end
    end

    // Hold counter: armed only by an accepted press, dropped on release or mode change.
    always_ff @(posedge clk) begin
        if (rst || clr || !btn_inc) begin
            armed_q <= 1'b0;
            phase_q <= 1'b0;
            cnt_q   <= '0;
        end else if (edge_c && en) begin
            armed_q <= 1'b1;
            phase_q <= 1'b0;
            cnt_q   <= HOLD_W'(1);
        end else if (armed_q) begin
            if (rep_c) begin
                phase_q <= 1'b1;
                cnt_q   <= '0;
            end else begin
                cnt_q   <= cnt_inc_c;
            end
        end
    end

    assign inc_evt_c = en & (edge_c | rep_c);
`else
    assign inc_evt_c = en & edge_c;
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: mode FSM, increment routing, inactivity timeout, blink.
// Optional macro AUTO_REPEAT_EN enables held-button auto-repeat.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_S     = 10
`ifdef AUTO_REPEAT_EN
   ,parameter int unsigned REPEAT_START  = 25_000_000
   ,parameter int unsigned REPEAT_PERIOD = 5_000_000
`endif
)(
    input  logic             clk,
    input  logic             rst,
    clock_set_ctrl_if.slave  bus
);

    mode_e           state_q, state_n;
    logic [TO_W-1:0] to_q, to_n;
    logic            blink_q, blink_n;
    logic            run_en_q, inc_h_q, inc_m_q, inc_s_q, clr_s_q;
    logic            inc_h_n, inc_m_n, inc_s_n, clr_s_n;
    logic            inc_evt_c;
    logic            set_c;
    logic            mode_chg_c;

    assign set_c      = (state_q != RUN);
    assign mode_chg_c = (state_n != state_q);

    // Press/auto-repeat event source.
    inc_pulse_gen
`ifdef AUTO_REPEAT_EN
    #(
        .REPEAT_START  (REPEAT_START),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    )
`endif
    u_inc (
        .clk       (clk),
        .rst       (rst),
        .en        (set_c),
`ifdef AUTO_REPEAT_EN
        .clr       (mode_chg_c),
`endif
        .btn_inc   (bus.btn_inc),
        .inc_evt_c (inc_evt_c)
    );

    // Next-state, timeout, blink and strobe decode; btn_mode beats an increment.
    always_comb begin
        state_n = state_q;
        to_n    = to_q;
        blink_n = blink_q;
        inc_h_n = 1'b0;
        inc_m_n = 1'b0;
        inc_s_n = 1'b0;
        clr_s_n = 1'b0;
        if (bus.btn_mode) begin
            state_n = mode_e'(state_q + 2'd1);
            to_n    = '0;
            blink_n = 1'b0;
            clr_s_n = (state_q == SET_S);
        end else if (set_c) begin
            if (bus.tick_1hz) blink_n = ~blink_q;
            if (inc_evt_c) begin
                to_n = '0;
                case (state_q)
                    SET_H:   inc_h_n = 1'b1;
                    SET_M:   inc_m_n = 1'b1;
                    SET_S:   inc_s_n = 1'b1;
                    default: ;
                endcase
            end else if (bus.tick_1hz) begin
                if (to_q == TO_W'(TIMEOUT_S - 1)) begin
                    state_n = RUN;
                    to_n    = '0;
                    blink_n = 1'b0;
                end else begin
                    to_n = to_q + TO_W'(1);
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            to_q     <= '0;
            blink_q  <= 1'b0;
            run_en_q <= 1'b1;
            inc_h_q  <= 1'b0;
            inc_m_q  <= 1'b0;
            inc_s_q  <= 1'b0;
            clr_s_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            to_q     <= to_n;
            blink_q  <= blink_n;
            run_en_q <= (state_n == RUN);
            inc_h_q  <= inc_h_n;
            inc_m_q  <= inc_m_n;
            inc_s_q  <= inc_s_n;
            clr_s_q  <= clr_s_n;
        end
    end

    assign bus.run_en = run_en_q;
    assign bus.inc_h  = inc_h_q;
    assign bus.inc_m  = inc_m_q;
    assign bus.inc_s  = inc_s_q;
    assign bus.clr_s  = clr_s_q;
    assign bus.mode   = state_q;
    assign bus.blink  = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized + directed bench for clock_set_ctrl against a behavioural model.
module tb_clock_set_ctrl;

    localparam int TIMEOUT = 10;
`ifdef AUTO_REPEAT_EN
    localparam int RS = 20;
    localparam int RP = 5;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clock_set_ctrl_if bus();

`ifdef AUTO_REPEAT_EN
    clock_set_ctrl #(.TIMEOUT_S(TIMEOUT), .REPEAT_START(RS), .REPEAT_PERIOD(RP))
        dut (.clk(clk), .rst(rst), .bus(bus));
`else
    clock_set_ctrl #(.TIMEOUT_S(TIMEOUT))
        dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model state.
    int m_mode, m_to, m_blink, m_hist, m_armed, m_held;
    int e_run, e_h, e_m, e_s, e_clr;
    // Tallies of observed strobes.
    int t_h, t_m, t_s, t_clr;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock of the specified behaviour, giving outputs after the edge.
    task automatic model(input int r, input int tick, input int bm, input int bi);
        int rise, rep, evt, old;
        e_h = 0; e_m = 0; e_s = 0; e_clr = 0;
        if (r != 0) begin
            m_mode = 0; m_to = 0; m_blink = 0; m_hist = 0; m_armed = 0; m_held = 0;
        end else begin
            rise = (bi != 0 && m_hist == 0) ? 1 : 0;
            rep  = 0;
`ifdef AUTO_REPEAT_EN
            if (bi != 0 && m_hist != 0 && m_armed != 0) begin
                m_held++;
                if (m_held == RS || (m_held > RS && (m_held - RS) % RP == 0)) rep = 1;
            end
`endif
            evt = (m_mode != 0 && (rise != 0 || rep != 0)) ? 1 : 0;
            old = m_mode;
            if (bm != 0) begin
                m_mode  = (m_mode + 1) % 4;
                e_clr   = (old == 3) ? 1 : 0;
                m_to    = 0;
                m_blink = 0;
            end else if (m_mode != 0) begin
                if (tick != 0) m_blink = 1 - m_blink;
                if (evt != 0) begin
                    m_to = 0;
                    if (old == 1) e_h = 1;
                    if (old == 2) e_m = 1;
                    if (old == 3) e_s = 1;
                end else if (tick != 0) begin
                    m_to++;
                    if (m_to == TIMEOUT) begin
                        m_mode = 0; m_to = 0; m_blink = 0;
                    end
                end
            end
            if (bi == 0 || m_mode != old) begin
                m_armed = 0; m_held = 0;
            end else if (rise != 0 && old != 0) begin
                m_armed = 1; m_held = 1;
            end
            m_hist = bi;
        end
        e_run = (m_mode == 0) ? 1 : 0;
    endtask

    // Drive one cycle (called just after a negedge), then compare at the next negedge.
    task automatic step(input int r, input int tick, input int bm, input int bi);
        rst          = (r != 0);
        bus.tick_1hz = (tick != 0);
        bus.btn_mode = (bm != 0);
        bus.btn_inc  = (bi != 0);
        model(r, tick, bm, bi);
        @(negedge clk);
        check("run_en", int'(bus.run_en), e_run);
        check("mode",   int'(bus.mode),   m_mode);
        check("inc_h",  int'(bus.inc_h),  e_h);
        check("inc_m",  int'(bus.inc_m),  e_m);
        check("inc_s",  int'(bus.inc_s),  e_s);
        check("clr_s",  int'(bus.clr_s),  e_clr);
        check("blink",  int'(bus.blink),  m_blink);
        t_h   += int'(bus.inc_h);
        t_m   += int'(bus.inc_m);
        t_s   += int'(bus.inc_s);
        t_clr += int'(bus.clr_s);
        check("one_hot_inc", (int'(bus.inc_h) + int'(bus.inc_m) + int'(bus.inc_s) <= 1) ? 1 : 0, 1);
    endtask

    task automatic clear_tally();
        t_h = 0; t_m = 0; t_s = 0; t_clr = 0;
    endtask

    // Press btn_mode until the model reaches the target mode (at most 4 presses).
    task automatic goto_mode(input int tgt);
        for (int k = 0; k < 4 && m_mode != tgt; k++) step(0, 0, 1, 0);
    endtask

    int exp_cnt;

    initial begin
        rst = 1'b1;
        bus.tick_1hz = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        m_mode = 0; m_to = 0; m_blink = 0; m_hist = 0; m_armed = 0; m_held = 0;
        clear_tally();
        @(negedge clk);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // Full mode cycle; clr_s only on the SET_S->RUN step.
        clear_tally();
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0);
            check("cycle_mode", int'(bus.mode), (k + 1) % 4);
            check("cycle_clr", int'(bus.clr_s), (k == 3) ? 1 : 0);
        end
        check("cycle_clr_total", t_clr, 1);

        // Long hold in SET_H.
        goto_mode(1);
        clear_tally();
        step(0, 0, 0, 1);
        check("hold_first_strobe", int'(bus.inc_h), 1);
        for (int k = 1; k < 100; k++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
`ifdef AUTO_REPEAT_EN
        exp_cnt = 1 + ((100 >= RS) ? (100 - RS) / RP + 1 : 0);
`else
        exp_cnt = 1;
`endif
        check("hold100_inc_h", t_h, exp_cnt);
        check("hold100_inc_m", t_m, 0);
        check("hold100_inc_s", t_s, 0);

        // Timeout in SET_M.
        goto_mode(2);
        clear_tally();
        for (int k = 0; k < TIMEOUT; k++) begin
            step(0, 0, 0, 0);
            step(0, 1, 0, 0);
            check("to_mode", int'(bus.mode), (k == TIMEOUT - 1) ? 0 : 2);
            check("to_blink", int'(bus.blink), (k == TIMEOUT - 1) ? 0 : (k + 1) % 2);
        end
        check("to_clr_total", t_clr, 0);

        // btn_mode and rising btn_inc together in SET_H.
        goto_mode(1);
        clear_tally();
        step(0, 0, 1, 1);
        check("simul_mode", int'(bus.mode), 2);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("simul_inc_h", t_h, 0);
        check("simul_inc_m", t_m, 0);

        // Reset for 2 cycles while in SET_M.
        goto_mode(2);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_mode", int'(bus.mode), 0);
        check("rst_run_en", int'(bus.run_en), 1);
        check("rst_blink", int'(bus.blink), 0);
        step(0, 0, 0, 0);

        // 40-cycle hold in SET_S.
        goto_mode(3);
        clear_tally();
        for (int k = 0; k < 40; k++) step(0, 0, 0, 1);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
`ifdef AUTO_REPEAT_EN
        exp_cnt = 6;
`else
        exp_cnt = 1;
`endif
        check("hold40_inc_s", t_s, exp_cnt);

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            int r, t, bm, bi;
            r  = ($urandom_range(0, 299) == 0) ? 1 : 0;
            t  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            bm = ($urandom_range(0, 19) == 0) ? 1 : 0;
            bi = int'(bus.btn_inc);
            if ($urandom_range(0, 5) == 0) bi = 1 - bi;
            step(r, t, bm, bi);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-setting controller for the wall-clock datapath; sits between the debounced front-panel buttons and the seconds/minutes/hours counters.
- Sequences the user through setting hours, minutes and seconds.
- Issues single-cycle increment strobes to the selected counter.
- Gates normal timekeeping (run_en) while a field is being set, and returns to run mode on command or after an inactivity timeout.

Parameters:
TIMEOUT_S, 10, number of tick_1hz pulses with no accepted button event before a set state auto-returns to RUN (1..63)
REPEAT_START, 25_000_000, clk cycles btn_inc must be held before auto-repeat begins (AUTO_REPEAT_EN only)
REPEAT_PERIOD, 5_000_000, clk cycles between auto-repeat strobes (AUTO_REPEAT_EN only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick_1hz  in  1  one-cycle pulse once per second from the prescaler
btn_mode  in  1  debounced mode button, one-cycle pulse per press
btn_inc  in  1  debounced increment button, level (1 = held)
run_en  out  1  1 = counters advance on tick_1hz; 0 while setting
inc_h  out  1  one-cycle increment strobe to hour counter
inc_m  out  1  one-cycle increment strobe to minute counter
inc_s  out  1  one-cycle increment strobe to second counter
clr_s  out  1  one-cycle clear strobe to second counter
mode  out  2  current state: 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
blink  out  1  display blink phase for the selected field

Behaviour:
- All outputs registered. rst (sampled on posedge clk) forces:
  - state RUN, run_en=1, mode=0
  - inc_h/inc_m/inc_s/clr_s=0, blink=0
  - timeout counter=0, btn_inc history register=0
- FSM states: RUN, SET_H, SET_M, SET_S.
  - btn_mode=1 advances RUN->SET_H->SET_M->SET_S->RUN; the new state is visible the next cycle.
- run_en=1 only in RUN.
- clr_s pulses for exactly one cycle, concurrent with mode becoming 0, only on the SET_S->RUN transition caused by btn_mode. The timeout return does not clear seconds.
- Increment event: rising edge of btn_inc (btn_inc=1 while history register=0).
  - Latency: strobe asserted the cycle after btn_inc first samples 1.
  - Strobe goes to the counter selected by the current state: SET_H->inc_h, SET_M->inc_m, SET_S->inc_s.
  - In RUN, increment events are ignored; no strobe.
  - At most one inc_* high in any cycle.
- Simultaneous btn_mode and increment event: mode wins, increment dropped.
- Timeout counter (6 bits):
  - Counts tick_1hz only in set states.
  - Cleared on every accepted btn_mode or increment event, and on entry to RUN.
  - When count reaches TIMEOUT_S on a tick, state goes to RUN next cycle.
  - Button event and tick in the same cycle: button wins, counter cleared.
- blink:
  - Cleared to 0 on entering any set state.
  - Toggles on each tick_1hz while in a set state.
  - Forced 0 in RUN.
- Wrap-around of counter values is the counters' responsibility; this block only strobes.
- Holding btn_inc across a mode change produces no strobe in the new state until released and re-pressed (history register is not reset on mode change).

Optional Feature:
Macro AUTO_REPEAT_EN.
- Defined:
  - While btn_inc is held in a set state, a hold counter runs.
  - After REPEAT_START cycles held, one extra strobe is issued, then one every REPEAT_PERIOD cycles.
  - Each repeat strobe clears the timeout counter.
  - Release, a mode change, or rst clears the hold counter.
- Undefined: hold counter logic absent; exactly one strobe per press.

Decomposition:
- Package clock_ctrl_pkg:
  - Mode enum typedef (RUN=0, SET_H=1, SET_M=2, SET_S=3).
  - Timeout counter width constant (6).
- Sub-module inc_pulse_gen: btn_inc edge detection plus the AUTO_REPEAT_EN hold/repeat counter.
  - Outputs a one-cycle inc_evt and is cleared by a mode-change input.
  - The top level does FSM, routing, timeout and blink.

Test Plan:
- rst=1 for 2 cycles mid-SET_M -> mode=0, run_en=1, all strobes 0, blink=0 next cycle.
- 4 btn_mode pulses from RUN -> mode 1,2,3,0; run_en 0 in 1..3; clr_s=1 for exactly the cycle mode returns to 0.
- In SET_H, btn_inc held 1 for 100 cycles (macro undefined) -> exactly one inc_h, one cycle after btn_inc rises; inc_m=inc_s=0.
- In SET_M, no buttons, 10 tick_1hz pulses -> mode=0 the cycle after the 10th tick; clr_s stays 0; blink toggled 9 times, then 0.
- btn_mode and btn_inc rising edge in the same cycle in SET_H -> mode=2, no inc_h, no inc_m.
- AUTO_REPEAT_EN, REPEAT_START=20, REPEAT_PERIOD=5, btn_inc held 40 cycles in SET_S -> inc_s at hold cycles 1, 20, 25, 30, 35, 40; none after release.
